// File: rtl/placement_eval.sv
// rtl/placement_eval.sv - sequential edge wirelength evaluator over external edge and position memories
// One edge per 8 cycles: fetch endpoints, fetch both positions, take |dx|,|dy|, accumulate.
module placement_eval #(
  parameter int N_EDGE = 42,
  parameter int DW     = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          re_edge,
  output logic [DW-1:0] addr_edge,
  input  logic [DW-1:0] edge_a,
  input  logic [DW-1:0] edge_b,
  output logic          re_pos,
  output logic [DW-1:0] addr_pos,
  input  logic [DW-1:0] pos_x,
  input  logic [DW-1:0] pos_y,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] sum,
  output logic [DW-1:0] sum_1hop,
  output logic          err
);

  typedef enum logic [3:0] {
    IDLE, EDGE, EDGE_W, POS_A, POS_A_W, POS_B, POS_B_W, DIFF, ACC, DONE
  } state_t;

  localparam logic [DW-1:0] N_CNT = DW'(N_EDGE);
  localparam logic [DW-1:0] ONE   = DW'(1);
  localparam logic [DW-1:0] ONES  = '1;

  state_t        state;
  logic [DW-1:0] i, ra, rb, ax, ay, bx, by, dx, dy;
  logic [DW-1:0] diff_x, diff_y, half_x, half_y, i_next;
  logic          any_unplaced;

  assign diff_x       = ax - bx;
  assign diff_y       = ay - by;
  // Rounded-up half distance: (d >> 1) + d[0]
  assign half_x       = (dx >> 1) + {{(DW-1){1'b0}}, dx[0]};
  assign half_y       = (dy >> 1) + {{(DW-1){1'b0}}, dy[0]};
  assign i_next       = i + ONE;
  assign any_unplaced = (ax == ONES) || (ay == ONES) || (bx == ONES) || (by == ONES);

  assign re_edge   = (state == EDGE);
  assign addr_edge = re_edge ? i : '0;
  assign re_pos    = (state == POS_A) || (state == POS_B);
  assign addr_pos  = (state == POS_A) ? ra : (state == POS_B) ? rb : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      i        <= '0;
      ra       <= '0;
      rb       <= '0;
      ax       <= '0;
      ay       <= '0;
      bx       <= '0;
      by       <= '0;
      dx       <= '0;
      dy       <= '0;
      sum      <= '0;
      sum_1hop <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            i        <= '0;
            sum      <= '0;
            sum_1hop <= '0;
            err      <= 1'b0;
            busy     <= 1'b1;
            if (N_EDGE == 0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= EDGE;
            end
          end
        end
        EDGE:    state <= EDGE_W;
        EDGE_W: begin
          ra    <= edge_a;
          rb    <= edge_b;
          state <= POS_A;
        end
        POS_A:   state <= POS_A_W;
        POS_A_W: begin
          ax    <= pos_x;
          ay    <= pos_y;
          state <= POS_B;
        end
        POS_B:   state <= POS_B_W;
        POS_B_W: begin
          bx    <= pos_x;
          by    <= pos_y;
          state <= DIFF;
        end
        DIFF: begin
          dx    <= diff_x[DW-1] ? ('0 - diff_x) : diff_x;
          dy    <= diff_y[DW-1] ? ('0 - diff_y) : diff_y;
          state <= ACC;
        end
        ACC: begin
          // An unplaced endpoint poisons the run but leaves the totals untouched
          if (any_unplaced) begin
            err <= 1'b1;
          end else begin
            sum      <= sum + dx + dy - ONE;
            sum_1hop <= sum_1hop + half_x + half_y - ONE;
          end
          i <= i_next;
          if (i_next == N_CNT) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= EDGE;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_placement_eval.sv
// tb/tb_placement_eval.sv - bench for placement_eval with N_EDGE = 0, 1, 2 and 42 instances
// Shared edge/position memories; a per-cycle monitor compares every instance against a timing/arithmetic model.
module tb_placement_eval;

  logic             clk;
  logic             reset;
  logic [3:0]       start_v;
  logic [3:0]       re_edge_v, re_pos_v, busy_v, done_v, err_v;
  logic [3:0][31:0] addr_edge_v, addr_pos_v, sum_v, s1_v;

  logic [31:0] edge_a_mem [64];
  logic [31:0] edge_b_mem [64];
  logic [31:0] pos_x_mem  [64];
  logic [31:0] pos_y_mem  [64];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    localparam int NE = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 2 : 42;
    logic [31:0] ea = '0, eb = '0, px = '0, py = '0;

    placement_eval #(.N_EDGE(NE), .DW(32)) u_dut (
      .clk(clk), .reset(reset), .start(start_v[g]),
      .re_edge(re_edge_v[g]), .addr_edge(addr_edge_v[g]),
      .edge_a(ea), .edge_b(eb),
      .re_pos(re_pos_v[g]), .addr_pos(addr_pos_v[g]),
      .pos_x(px), .pos_y(py),
      .busy(busy_v[g]), .done(done_v[g]),
      .sum(sum_v[g]), .sum_1hop(s1_v[g]), .err(err_v[g])
    );

    always @(posedge clk) begin
      if (re_edge_v[g]) begin
        ea <= edge_a_mem[addr_edge_v[g][5:0]];
        eb <= edge_b_mem[addr_edge_v[g][5:0]];
      end
      if (re_pos_v[g]) begin
        px <= pos_x_mem[addr_pos_v[g][5:0]];
        py <= pos_y_mem[addr_pos_v[g][5:0]];
      end
    end
  end

  function automatic int ne(input int g);
    return (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 2 : 42;
  endfunction

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut=%0d cyc=%0d got=%0h expected=%0h", nm, g, cyc, act, exp);
    end
  endtask

  // Wirelength totals straight from the arithmetic rules, using wide integers
  function automatic void model(input int n, output logic [31:0] s, output logic [31:0] s1, output bit e);
    s = '0; s1 = '0; e = 1'b0;
    for (int j = 0; j < n; j++) begin
      logic [31:0] ax, ay, bx, by;
      int          di, dj;
      longint      dxl, dyl;
      ax = pos_x_mem[edge_a_mem[j][5:0]];
      ay = pos_y_mem[edge_a_mem[j][5:0]];
      bx = pos_x_mem[edge_b_mem[j][5:0]];
      by = pos_y_mem[edge_b_mem[j][5:0]];
      if (ax == 32'hFFFF_FFFF || ay == 32'hFFFF_FFFF || bx == 32'hFFFF_FFFF || by == 32'hFFFF_FFFF) begin
        e = 1'b1;
      end else begin
        di  = $signed(ax - bx);
        dj  = $signed(ay - by);
        dxl = (di < 0) ? -longint'(di) : longint'(di);
        dyl = (dj < 0) ? -longint'(dj) : longint'(dj);
        s   = s + 32'(dxl + dyl - 1);
        s1  = s1 + 32'((dxl + 1) / 2 + (dyl + 1) / 2 - 1);
      end
    end
  endfunction

  bit          m_active [4];
  int          m_k      [4];
  logic [31:0] m_sum    [4], m_s1 [4], r_sum [4], r_s1 [4];
  bit          m_err    [4], r_err [4];

  initial begin : monitor
    bit prev_reset, armed;
    prev_reset = 1'b0;
    armed      = 1'b0;
    for (int g = 0; g < 4; g++) begin
      m_active[g] = 1'b0; m_k[g] = 0;
      m_sum[g] = '0; m_s1[g] = '0; m_err[g] = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (prev_reset) armed = 1'b1;
      for (int g = 0; g < 4; g++) begin
        int          n, off;
        bit          e_done, e_re_e, e_re_p;
        logic [31:0] e_ae, e_ap;
        if (prev_reset) begin
          m_active[g] = 1'b0; m_sum[g] = '0; m_s1[g] = '0; m_err[g] = 1'b0;
        end
        if (armed) begin
          n      = ne(g);
          off    = cyc - m_k[g];
          e_done = m_active[g] && (off == 8 * n);
          e_re_e = m_active[g] && (off < 8 * n) && (off % 8 == 0);
          e_re_p = m_active[g] && (off < 8 * n) && (off % 8 == 2 || off % 8 == 4);
          e_ae   = e_re_e ? 32'(off / 8) : 32'd0;
          e_ap   = !e_re_p ? 32'd0 : (off % 8 == 2) ? edge_a_mem[off / 8] : edge_b_mem[off / 8];
          chk("busy",      g, 32'(busy_v[g]),    32'(m_active[g]));
          chk("done",      g, 32'(done_v[g]),    32'(e_done));
          chk("re_edge",   g, 32'(re_edge_v[g]), 32'(e_re_e));
          chk("addr_edge", g, addr_edge_v[g],    e_ae);
          chk("re_pos",    g, 32'(re_pos_v[g]),  32'(e_re_p));
          chk("addr_pos",  g, addr_pos_v[g],     e_ap);
          if (e_done) begin
            chk("sum_done",  g, sum_v[g],        r_sum[g]);
            chk("s1_done",   g, s1_v[g],         r_s1[g]);
            chk("err_done",  g, 32'(err_v[g]),   32'(r_err[g]));
          end else if (!m_active[g]) begin
            chk("sum_hold",  g, sum_v[g],        m_sum[g]);
            chk("s1_hold",   g, s1_v[g],         m_s1[g]);
            chk("err_hold",  g, 32'(err_v[g]),   32'(m_err[g]));
          end
          if (!m_active[g] && start_v[g] && !reset) begin
            m_active[g] = 1'b1;
            m_k[g]      = cyc + 1;
            model(n, r_sum[g], r_s1[g], r_err[g]);
          end
          if (e_done) begin
            m_active[g] = 1'b0;
            m_sum[g] = r_sum[g]; m_s1[g] = r_s1[g]; m_err[g] = r_err[g];
          end
        end
      end
      prev_reset = reset;
    end
  end

  task automatic run(input int g, input bit jam);
    int n, k, lat;
    bit got;
    n = ne(g); got = 1'b0; lat = 0;
    @(posedge clk); #1; start_v[g] = 1'b1; k = cyc + 1;
    @(posedge clk); #1; start_v[g] = 1'b0;
    for (int t = 0; t < 8 * n + 20 && !got; t++) begin
      @(negedge clk);
      if (done_v[g]) begin
        got = 1'b1;
        lat = cyc - k + 1;
      end else if (jam) begin
        @(posedge clk); #1;
        start_v[g] = (cyc - k <= 8 * n) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    @(posedge clk); #1; start_v[g] = 1'b0;
    chk("done_seen", g, 32'(got), 32'd1);
    if (got) chk("latency", g, 32'(lat), 32'(1 + 8 * n));
  endtask

  function automatic logic [31:0] rpos(input bit allow_unplaced);
    int r, v;
    r = $urandom_range(0, 99);
    v = $urandom_range(0, 1000) - 500;
    if (allow_unplaced && r < 3) return 32'hFFFF_FFFF;
    if (r < 6) return 32'($urandom);
    return 32'(v);
  endfunction

  task automatic randomize_mem(input bit allow_unplaced);
    for (int j = 0; j < 64; j++) begin
      edge_a_mem[j] = 32'($urandom_range(0, 63));
      edge_b_mem[j] = ($urandom_range(0, 9) == 0) ? edge_a_mem[j] : 32'($urandom_range(0, 63));
      pos_x_mem[j]  = rpos(allow_unplaced);
      pos_y_mem[j]  = rpos(allow_unplaced);
    end
  endtask

  task automatic set_pos(input int id, input int x, input int y);
    pos_x_mem[id] = 32'(x);
    pos_y_mem[id] = 32'(y);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "bench did not finish");
  end

  initial begin
    int k;
    reset   = 1'b1;
    start_v = '0;
    for (int j = 0; j < 64; j++) begin
      edge_a_mem[j] = '0; edge_b_mem[j] = '0; pos_x_mem[j] = '0; pos_y_mem[j] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy",  3, 32'(busy_v[3]),  32'd0);
    chk("rst_sum",   3, sum_v[3],        32'd0);
    chk("rst_addr",  3, addr_pos_v[3],   32'd0);

    // Single edge, (0,0) to (3,4)
    edge_a_mem[0] = 0; edge_b_mem[0] = 1;
    set_pos(0, 0, 0); set_pos(1, 3, 4);
    run(1, 1'b0);
    @(negedge clk);
    chk("lit031_sum", 1, sum_v[1], 32'd6);
    chk("lit031_s1",  1, s1_v[1],  32'd3);
    chk("lit031_err", 1, 32'(err_v[1]), 32'd0);

    // Coincident pair then a 5-unit edge
    edge_a_mem[0] = 0; edge_b_mem[0] = 1; edge_a_mem[1] = 1; edge_b_mem[1] = 2;
    set_pos(0, 0, 0); set_pos(1, 0, 0); set_pos(2, 5, 0);
    run(2, 1'b0);
    @(negedge clk);
    chk("lit032_sum", 2, sum_v[2], 32'd3);
    chk("lit032_s1",  2, s1_v[2],  32'd1);

    // Unplaced endpoint on edge 0; err must persist through idle
    edge_a_mem[0] = 0; edge_b_mem[0] = 1; edge_a_mem[1] = 2; edge_b_mem[1] = 3;
    set_pos(0, 0, 0); set_pos(1, 0, -1); set_pos(2, 0, 0); set_pos(3, 1, 1);
    run(2, 1'b0);
    repeat (6) @(negedge clk);
    chk("lit033_err", 2, 32'(err_v[2]), 32'd1);
    chk("lit033_sum", 2, sum_v[2], 32'd1);
    chk("lit033_s1",  2, s1_v[2],  32'd1);
    set_pos(1, 0, 0);
    run(2, 1'b0);
    @(negedge clk);
    chk("lit033_clr", 2, 32'(err_v[2]), 32'd0);
    chk("lit033_sum2", 2, sum_v[2], 32'd0);

    // Zero-edge instance
    run(0, 1'b0);
    @(negedge clk);
    chk("lit036_sum", 0, sum_v[0], 32'd0);

    // Start coincident with reset is dropped
    @(posedge clk); #1; reset = 1'b1; start_v[1] = 1'b1;
    @(posedge clk); #1; reset = 1'b0; start_v[1] = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", 1, 32'(busy_v[1]), 32'd0);

    // Randomized runs, half with start jammed while busy
    for (int r = 0; r < 6; r++) begin
      randomize_mem(r % 3 != 0);
      run(3, r[0]);
      run(1 + (r % 2), ~r[0]);
    end

    // Reset during edge 3 of 42, then a clean run
    randomize_mem(1'b0);
    @(posedge clk); #1; start_v[3] = 1'b1; k = cyc + 1;
    @(posedge clk); #1; start_v[3] = 1'b0;
    for (int t = 0; t < 100 && cyc < k + 26; t++) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 3, 32'(busy_v[3]), 32'd0);
    chk("abort_done", 3, 32'(done_v[3]), 32'd0);
    chk("abort_sum",  3, sum_v[3], 32'd0);
    chk("abort_s1",   3, s1_v[3],  32'd0);
    run(3, 1'b0);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
